uart_tx_block: RTL

Serial transmitter for the 8N1-style serial link whose receive end synchronizes the incoming line into its own clock domain. It accepts a parallel byte through a start/busy handshake and shifts out a frame: start bit (0), data LSB first, stop bit(s) (1). A bit-period counter times each bit. Line idle level is 1. Sits at the serial output pin of the link, ahead of any pad logic.

---
 rtl/uart_tx_block.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_tx_block.sv
// Serial transmitter: start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits.
// A bit-period counter times each bit; all outputs are registered.
module uart_tx_block #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned BIT_PERIOD = 10,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_overrun
);

    localparam int unsigned CntW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int unsigned IdxW = $clog2(DATA_BITS);

    localparam logic [CntW-1:0] CntLast  = CntW'(BIT_PERIOD - 1);
    localparam logic [IdxW-1:0] DataLast = IdxW'(DATA_BITS - 1);
    localparam logic [IdxW-1:0] StopLast = IdxW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   serial_q, serial_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ovr_q, ovr_d;
    logic                   bit_end;

    assign bit_end = (cnt_q == CntLast);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovr_d    = 1'b0;

        if (state_q != StIdle) begin
            ovr_d = tx_start;
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (tx_start) begin
                    state_d  = StStart;
                    shift_d  = tx_data;
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d  = StData;
                    idx_d    = '0;
                    serial_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == DataLast) begin
                        state_d  = StStop;
                        idx_d    = '0;
                        serial_d = 1'b1;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        serial_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                    end
                end
            end
            StStop: begin
                // idx_q is reused to count stop bits
                if (bit_end) begin
                    if (idx_q == StopLast) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    assign serial_out = serial_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_overrun = ovr_q;

endmodule
